// File: rtl/resultado_bcd_pkg.sv
// Shared definitions for the result-to-BCD decoder: FSM states and the
// constants used by the double-dabble add-3 correction.
package resultado_bcd_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   localparam int BCD_W = 4;

   localparam logic [BCD_W-1:0] ADD3_THRESH = 4'd5;
   localparam logic [BCD_W-1:0] ADD3_VAL    = 4'd3;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_add3
   import resultado_bcd_pkg::*;
(
   input  logic [BCD_W-1:0] din_i,
   output logic [BCD_W-1:0] dout_o
);

   // Conditional +3 on a single digit.
   always_comb begin
      dout_o = din_i;
      if (din_i >= ADD3_THRESH) begin
         dout_o = din_i + ADD3_VAL;
      end
   end

endmodule

// File: rtl/resultado_bcd.sv
// Converts the add/subtract unit's {cout,result} into sign + BCD digits
// using a sequential double-dabble, one magnitude bit per clock.
module resultado_bcd
   import resultado_bcd_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    sel,
   input  logic [WIDTH-1:0]        result,
   input  logic                    cout,
   output logic                    busy,
   output logic                    done,
   output logic                    sign,
   output logic [BCD_W*DIGITS-1:0] digits
);

   localparam int CNT_W   = $clog2(WIDTH + 2);
   localparam int BCD_TOT = BCD_W * DIGITS;
   localparam logic [WIDTH:0] MAG_MOD = {1'b1, {WIDTH{1'b0}}};
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

   state_t               state_q, state_d;
   logic [WIDTH:0]       mag_q, mag_d;
   logic [BCD_TOT-1:0]   bcd_q, bcd_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 signPend_q, signPend_d;
   logic                 sign_q, sign_d;
   logic                 done_q, done_d;
   logic [BCD_TOT-1:0]   digits_q, digits_d;

   logic [WIDTH:0]       magCapture;
   logic                 signCapture;
   logic [BCD_TOT-1:0]   bcdAdj;
   logic [BCD_TOT-1:0]   bcdShift;
   logic [WIDTH:0]       magShift;
   logic                 unusedBcdMsb;

   // One add-3 corrector per BCD digit, applied before every shift.
   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : gAdd3
         bcd_add3 uAdd3 (
            .din_i  (bcd_q[g*BCD_W +: BCD_W]),
            .dout_o (bcdAdj[g*BCD_W +: BCD_W])
         );
      end
   endgenerate

   // The {bcd,mag} pair shifts left as one register; the top BCD bit falls
   // off because the hundreds digit never reaches 8 for a 9-bit magnitude.
   assign bcdShift     = {bcdAdj[BCD_TOT-2:0], mag_q[WIDTH]};
   assign magShift     = {mag_q[WIDTH-1:0], 1'b0};
   assign unusedBcdMsb = bcdAdj[BCD_TOT-1];

   // Magnitude and sign of the incoming operation; a borrow on subtract
   // means the result is negative and its magnitude is 2^WIDTH - result.
   always_comb begin
      magCapture  = {cout, result};
      signCapture = 1'b0;
      if (sel) begin
         if (cout) begin
            magCapture = {1'b0, result};
         end else begin
            magCapture  = MAG_MOD - {1'b0, result};
            signCapture = 1'b1;
         end
      end
   end

   // Next-state logic: capture in IDLE, shift in CONV, publish on the last shift.
   always_comb begin
      state_d    = state_q;
      mag_d      = mag_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      signPend_d = signPend_q;
      sign_d     = sign_q;
      digits_d   = digits_q;
      done_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               mag_d      = magCapture;
               signPend_d = signCapture;
               bcd_d      = '0;
               cnt_d      = '0;
               state_d    = CONV;
            end
         end
         CONV: begin
            bcd_d = bcdShift;
            mag_d = magShift;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               digits_d = bcdShift;
               sign_d   = signPend_q;
               done_d   = 1'b1;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any conversion immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         mag_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         signPend_q <= 1'b0;
         sign_q     <= 1'b0;
         done_q     <= 1'b0;
         digits_q   <= '0;
      end else begin
         state_q    <= state_d;
         mag_q      <= mag_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         signPend_q <= signPend_d;
         sign_q     <= sign_d;
         done_q     <= done_d;
         digits_q   <= digits_d;
      end
   end

   assign busy   = (state_q == CONV);
   assign done   = done_q;
   assign sign   = sign_q;
   assign digits = digits_q;

endmodule

// File: tb/tb_resultado_bcd.sv
// Scoreboard bench for resultado_bcd: stimulus pushes expected {sign,digits}
// into a queue, a negedge monitor pops and compares on every done pulse.
module tb_resultado_bcd;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        sel;
   logic [7:0]  result;
   logic        cout;
   logic        busy;
   logic        done;
   logic        sign;
   logic [11:0] digits;

   int          total = 0;
   int          bad = 0;
   logic [12:0] sbQ[$];
   logic        prevDone = 1'b0;

   resultado_bcd #(.WIDTH(8), .DIGITS(3)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .sel    (sel),
      .result (result),
      .cout   (cout),
      .busy   (busy),
      .done   (done),
      .sign   (sign),
      .digits (digits)
   );

   // 100 MHz-style free-running clock.
   always #5 clk = ~clk;

   // Global guard so a stuck DUT can never hang the run.
   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Independent reference: plain arithmetic and decimal division.
   function automatic logic [12:0] refModel(input logic s, input logic [7:0] r,
                                            input logic c);
      int m;
      logic neg;
      neg = 1'b0;
      if (!s) m = (c ? 256 : 0) + int'(r);
      else if (c) m = int'(r);
      else begin
         m   = 256 - int'(r);
         neg = 1'b1;
      end
      return {neg, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
   endfunction

   // Monitor: every done pulse must match the oldest outstanding request
   // and must never last more than one cycle.
   always @(negedge clk) begin
      if (rst_n && done) begin
         checkOutput("doneWidth", {31'b0, prevDone}, 32'd0);
         checkOutput("sbUnderflow", {31'b0, sbQ.size() == 0}, 32'd0);
         if (sbQ.size() > 0) begin
            logic [12:0] exp;
            exp = sbQ.pop_front();
            checkOutput("sign", {31'b0, sign}, {31'b0, exp[12]});
            checkOutput("digits", {20'b0, digits}, {20'b0, exp[11:0]});
         end
      end
      prevDone = rst_n ? done : 1'b0;
   end

   task automatic waitIdle();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      if (busy) checkOutput("idleTimeout", {31'b0, busy}, 32'd0);
   endtask

   // Issue one request at a negedge where the DUT is idle, record expectation.
   task automatic applyStimulus(input logic s, input logic [7:0] r, input logic c,
                                input logic [12:0] exp);
      waitIdle();
      sel    = s;
      result = r;
      cout   = c;
      start  = 1'b1;
      sbQ.push_back(exp);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Count negedges after the capture edge until done, and busy cycles seen.
   task automatic waitDone(output int lat, output int busyCnt);
      lat     = -1;
      busyCnt = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (busy) busyCnt++;
         if (done) begin
            lat = i;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      int bc;

      rst_n  = 1'b0;
      start  = 1'b0;
      sel    = 1'b0;
      result = 8'h00;
      cout   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rstBusy", {31'b0, busy}, 32'd0);
      checkOutput("rstDone", {31'b0, done}, 32'd0);
      checkOutput("rstSign", {31'b0, sign}, 32'd0);
      checkOutput("rstDigits", {20'b0, digits}, 32'd0);
      rst_n = 1'b1;

      // 250 + 250 with latency and busy-length checks.
      applyStimulus(1'b0, 8'hF4, 1'b1, 13'h0500);
      waitDone(lat, bc);
      checkOutput("latency1", lat, 32'd10);
      checkOutput("busyCycles1", bc, 32'd9);

      // 7-2 and 2-7.
      applyStimulus(1'b1, 8'h05, 1'b1, 13'h0005);
      applyStimulus(1'b1, 8'hFB, 1'b0, 13'h1005);

      // Boundaries.
      applyStimulus(1'b1, 8'h80, 1'b0, 13'h1128);
      applyStimulus(1'b0, 8'h00, 1'b0, 13'h0000);
      applyStimulus(1'b0, 8'hFF, 1'b0, 13'h0255);
      applyStimulus(1'b1, 8'h00, 1'b0, 13'h1256);
      applyStimulus(1'b0, 8'hFF, 1'b1, 13'h0511);

      // Start held through CONV with changing inputs: only the first counts.
      waitIdle();
      sel    = 1'b0;
      result = 8'h10;
      cout   = 1'b0;
      start  = 1'b1;
      sbQ.push_back(13'h0016);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         sel    = 1'b1;
         result = 8'h33 + 8'(k);
         cout   = 1'b0;
      end
      start = 1'b0;
      waitIdle();
      repeat (3) @(negedge clk);
      checkOutput("heldStartIdle", {31'b0, busy}, 32'd0);
      checkOutput("heldStartQueue", sbQ.size(), 32'd0);

      // Start in the done cycle: second done exactly 10 cycles later.
      applyStimulus(1'b0, 8'h64, 1'b0, 13'h0100);
      waitDone(lat, bc);
      checkOutput("latencyA", lat, 32'd10);
      sel    = 1'b1;
      result = 8'h01;
      cout   = 1'b0;
      start  = 1'b1;
      sbQ.push_back(13'h1255);
      @(posedge clk);
      #1 start = 1'b0;
      waitDone(lat, bc);
      checkOutput("backToBack", lat, 32'd10);

      // Reset in the middle of a conversion.
      applyStimulus(1'b0, 8'hC8, 1'b1, 13'h0456);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      sbQ.delete();
      #1;
      checkOutput("abortBusy", {31'b0, busy}, 32'd0);
      checkOutput("abortDone", {31'b0, done}, 32'd0);
      checkOutput("abortSign", {31'b0, sign}, 32'd0);
      checkOutput("abortDigits", {20'b0, digits}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("abortNoDone", {31'b0, done}, 32'd0);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         checkOutput("postAbortIdle", {31'b0, done | busy}, 32'd0);
      end
      applyStimulus(1'b1, 8'h2A, 1'b1, 13'h0042);
      waitDone(lat, bc);
      checkOutput("postAbortLat", lat, 32'd10);

      // Full sweep of (result,cout) for both modes against the model.
      for (int s = 0; s < 2; s++) begin
         for (int v = 0; v < 512; v++) begin
            logic [8:0] vv;
            vv = 9'(v);
            applyStimulus(1'(s), vv[7:0], vv[8], refModel(1'(s), vv[7:0], vv[8]));
         end
      end

      waitIdle();
      repeat (3) @(negedge clk);
      checkOutput("sbDrained", sbQ.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
